smart_uart_cmd_engine: RTL and testbench
========================================

Name: smart_uart_cmd_engine

Overview:
DUT-side responder for the smart-UART host protocol. It consumes bytes from the UART receiver and decodes SU_CMD_WR_WORD and SU_CMD_RD_WORD frames into 32-bit memory-mapped bus transactions. Read data is returned to the UART transmitter as an SU_CMD_RSP frame. Non-command bytes pass through to the core's character gateway, so terminal traffic and command traffic share one line.

Parameters:
RX_TIMEOUT_CYC, 1000000, idle clk cycles between command bytes before a partial frame is aborted
BUS_TIMEOUT_CYC, 256, clk cycles to wait for bus_ack before forcing completion
BUS_ERR_DATA, 32'hDEAD_BEEF, read data returned on bus timeout

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rx_byte  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_byte valid; no backpressure
tx_byte  out  8  byte to UART transmitter
tx_valid  out  1  tx_byte valid; held until tx_ready
tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
gw_byte  out  8  pass-through character to core gateway
gw_valid  out  1  one-cycle strobe for gw_byte
bus_req  out  1  bus request, held until bus_ack or timeout
bus_we  out  1  1=write, 0=read; stable while bus_req
bus_addr  out  32  word address
bus_wdata  out  32  write data
bus_rdata  in  32  read data, sampled when bus_ack
bus_ack  in  1  one-cycle completion
overrun  out  1  one-cycle pulse: rx byte dropped while busy
cmd_abort  out  1  one-cycle pulse: partial frame aborted (rx timeout)
bus_timeout  out  1  one-cycle pulse: bus_ack not seen within BUS_TIMEOUT_CYC

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. All outputs 0 except bus_addr, bus_wdata and tx_byte, which are also 0. Counters and shift registers are cleared. Reset mid-frame or mid-transaction drops it silently.
- Frame formats, all multi-byte fields MSB byte first:
  - Write: WR_WORD, A3..A0, D3..D0. No response.
  - Read: RD_WORD, A3..A0. Response: RSP, R3..R0.
- IDLE:
  - rx byte == SU_CMD_WR_WORD or SU_CMD_RD_WORD: latch opcode, go to ADDR, byte count 0.
  - Any other byte: gw_byte=rx_byte and gw_valid=1 on the next cycle; no state change.
- ADDR: each rx byte shifts into bus_addr (addr <= {addr[23:0],byte}). On the 4th byte:
  - WR: go to WDATA.
  - RD: go to BUS.
- WDATA: same shift into bus_wdata. On the 4th byte go to BUS.
- Inter-byte timeout (ADDR/WDATA): counter resets on every rx_valid. When it reaches RX_TIMEOUT_CYC, pulse cmd_abort and return to IDLE. Command bytes are never forwarded to the gateway.
- BUS:
  - bus_req=1 the cycle after entry; bus_we=(opcode==WR).
  - On bus_ack: deassert bus_req the same cycle it is sampled. WR returns to IDLE; RD captures bus_rdata and goes to RSP.
  - No ack after BUS_TIMEOUT_CYC cycles of bus_req: pulse bus_timeout and deassert bus_req. RD uses BUS_ERR_DATA as read data; WR returns to IDLE.
  - bus_ack while bus_req=0 is ignored.
- RSP: sends 5 bytes (SU_CMD_RSP, R3, R2, R1, R0) via valid/ready.
  - tx_valid stays asserted between bytes; the next byte is presented the cycle after each handshake.
  - After the 5th handshake, tx_valid=0 and state returns to IDLE.
  - tx_ready held low stalls indefinitely (no timeout).
- rx_valid in BUS or RSP: byte dropped, overrun pulses. No gateway forwarding.
- Minimum latency: 4th address byte (RD) to bus_req = 1 cycle; bus_ack to first tx_valid = 1 cycle.
- Back-to-back frames: a new WR/RD opcode is accepted in the first IDLE cycle.

Decomposition:
- Package smart_uart_pkg:
  - Opcode localparams mapped from the SU_CMD_WR_WORD / SU_CMD_RD_WORD / SU_CMD_RSP defines.
  - State enum t_su_state {IDLE, ADDR, WDATA, BUS, RSP}.
  - Frame length constants (ADDR_BYTES=4, DATA_BYTES=4, RSP_BYTES=5).
- One sub-module, su_rsp_serializer: loads a 32-bit word plus header and emits 5 bytes over the valid/ready handshake, asserting done when finished. The decoder FSM, timeouts and bus handshake stay in the top module.

Test Plan:
- Write 0x1000_0040 <= 0xCAFE_F00D with bus_ack 3 cycles after bus_req -> one bus_req, bus_we=1, addr/wdata exact, no tx_valid, then IDLE.
- Read 0x0000_0010, bus_rdata=0x1234_ABCD, tx_ready random -> tx bytes exactly SU_CMD_RSP, 12, 34, AB, CD, in order, each held until ready.
- Bytes "h","i",0x0A in IDLE -> three gw_valid pulses carrying 0x68, 0x69, 0x0A; bus and tx stay idle.
- RD opcode + 2 address bytes, then silence for RX_TIMEOUT_CYC -> cmd_abort pulse, IDLE. A following full write executes correctly.
- Read with bus_ack never asserted -> bus_timeout after 256 cycles; response RSP, DE, AD, BE, EF.
- rx byte arriving during RSP stall -> overrun pulse, response unchanged. rst_n=0 mid-ADDR -> all outputs 0, next frame decodes cleanly.

Source files
------------

// File: rtl/smart_uart_pkg.sv
// smart_uart_pkg: opcodes, FSM state type and frame-length constants for the smart-UART command engine
`ifndef SU_CMD_WR_WORD
`define SU_CMD_WR_WORD 8'hA1
`endif
`ifndef SU_CMD_RD_WORD
`define SU_CMD_RD_WORD 8'hA2
`endif
`ifndef SU_CMD_RSP
`define SU_CMD_RSP 8'hA3
`endif
package smart_uart_pkg;
  localparam logic [7:0] OPC_WR = `SU_CMD_WR_WORD;
  localparam logic [7:0] OPC_RD = `SU_CMD_RD_WORD;
  localparam logic [7:0] OPC_RSP = `SU_CMD_RSP;
  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 4;
  localparam int RSP_BYTES = 5;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RSP} t_su_state;
  function automatic logic is_cmd(input logic [7:0] b);
    return b == OPC_WR || b == OPC_RD;
  endfunction
endpackage

// File: rtl/smart_uart_cmd_engine_if.sv
// smart_uart_cmd_engine_if: UART rx/tx, gateway, bus and event signals of the command engine
interface smart_uart_cmd_engine_if;
  logic [7:0] rx_byte;
  logic rx_valid;
  logic [7:0] tx_byte;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] gw_byte;
  logic gw_valid;
  logic bus_req;
  logic bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic bus_ack;
  logic overrun;
  logic cmd_abort;
  logic bus_timeout;
  modport master (
    input rx_byte, rx_valid, tx_ready, bus_rdata, bus_ack,
    output tx_byte, tx_valid, gw_byte, gw_valid, bus_req, bus_we, bus_addr, bus_wdata,
    output overrun, cmd_abort, bus_timeout
  );
  modport slave (
    output rx_byte, rx_valid, tx_ready, bus_rdata, bus_ack,
    input tx_byte, tx_valid, gw_byte, gw_valid, bus_req, bus_we, bus_addr, bus_wdata,
    input overrun, cmd_abort, bus_timeout
  );
endinterface

// File: rtl/su_rsp_serializer.sv
// su_rsp_serializer: emits header plus 32-bit word MSB first over valid/ready, pulsing done on the last handshake
module su_rsp_serializer
  import smart_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [7:0]  i_hdr,
  input  logic [31:0] i_word,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_valid,
  output logic        o_done
);
  localparam int SW = RSP_BYTES * 8;
  logic [SW-1:0] r_sh;
  logic r_valid;
  logic [2:0] r_idx;
  logic w_hs;
  assign w_hs = r_valid && i_tx_ready;
  assign o_done = w_hs && r_idx == 3'(RSP_BYTES - 1);
  assign o_tx_byte = r_sh[SW-1 -: 8];
  assign o_tx_valid = r_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh <= '0;
      r_valid <= 1'b0;
      r_idx <= '0;
    end else if (i_load) begin
      r_sh <= {i_hdr, i_word};
      r_valid <= 1'b1;
      r_idx <= '0;
    end else if (w_hs) begin
      r_valid <= !o_done;
      r_idx <= r_idx + 3'd1;
      r_sh <= o_done ? r_sh : {r_sh[SW-9:0], 8'h00};
    end
  end
endmodule

// File: rtl/smart_uart_cmd_engine.sv
// smart_uart_cmd_engine: decodes WR_WORD/RD_WORD frames from the UART into bus cycles, returns RSP frames,
// and forwards all other bytes to the character gateway
module smart_uart_cmd_engine
  import smart_uart_pkg::*;
#(
  parameter int          RX_TIMEOUT_CYC  = 1000000,
  parameter int          BUS_TIMEOUT_CYC = 256,
  parameter logic [31:0] BUS_ERR_DATA    = 32'hDEAD_BEEF
) (
  input logic clk,
  input logic rst_n,
  smart_uart_cmd_engine_if.master io_su
);
  localparam int RW = $clog2(RX_TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BUS_TIMEOUT_CYC + 1);
  t_su_state r_state, w_next;
  logic r_wr;
  logic [1:0] r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic [RW-1:0] r_rx_tmr;
  logic [BW-1:0] r_bus_tmr;
  logic r_req, r_gw_valid, r_overrun, r_abort, r_btmo;
  logic [7:0] r_gw_byte;
  logic w_rx, w_in_frame, w_last, w_rx_tmo, w_ack, w_bus_tmo, w_bus_end, w_load, w_done, w_gw;
  logic [31:0] w_rword;
  logic [7:0] w_tx_byte;
  logic w_tx_valid;
  assign w_rx = io_su.rx_valid;
  assign w_in_frame = r_state == ADDR || r_state == WDATA;
  assign w_last = w_rx && r_cnt == (r_state == WDATA ? 2'(DATA_BYTES - 1) : 2'(ADDR_BYTES - 1));
  assign w_rx_tmo = w_in_frame && !w_rx && r_rx_tmr == RW'(RX_TIMEOUT_CYC - 1);
  assign w_ack = r_req && io_su.bus_ack;
  assign w_bus_tmo = r_req && !io_su.bus_ack && r_bus_tmr == BW'(BUS_TIMEOUT_CYC - 1);
  assign w_bus_end = w_ack || w_bus_tmo;
  assign w_load = r_state == BUS && !r_wr && w_bus_end;
  assign w_rword = w_ack ? io_su.bus_rdata : BUS_ERR_DATA;
  assign w_gw = r_state == IDLE && w_rx && !is_cmd(io_su.rx_byte);
  su_rsp_serializer u_rsp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_hdr      (OPC_RSP),
    .i_word     (w_rword),
    .i_tx_ready (io_su.tx_ready),
    .o_tx_byte  (w_tx_byte),
    .o_tx_valid (w_tx_valid),
    .o_done     (w_done)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_rx && is_cmd(io_su.rx_byte) ? ADDR : IDLE;
      ADDR:    w_next = w_rx_tmo ? IDLE : w_last ? (r_wr ? WDATA : BUS) : ADDR;
      WDATA:   w_next = w_rx_tmo ? IDLE : w_last ? BUS : WDATA;
      BUS:     w_next = w_bus_end ? (r_wr ? IDLE : RSP) : BUS;
      RSP:     w_next = w_done ? IDLE : RSP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= 1'b0;
      r_cnt <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rx_tmr <= '0;
      r_bus_tmr <= '0;
      r_req <= 1'b0;
      r_gw_valid <= 1'b0;
      r_gw_byte <= '0;
      r_overrun <= 1'b0;
      r_abort <= 1'b0;
      r_btmo <= 1'b0;
    end else begin
      if (r_state == IDLE && w_rx) r_wr <= io_su.rx_byte == OPC_WR;
      if (r_state == ADDR && w_rx) r_addr <= {r_addr[23:0], io_su.rx_byte};
      if (r_state == WDATA && w_rx) r_wdata <= {r_wdata[23:0], io_su.rx_byte};
      if (w_gw) r_gw_byte <= io_su.rx_byte;
      r_cnt <= w_in_frame && w_rx ? r_cnt + 2'd1 : w_in_frame ? r_cnt : 2'd0;
      // counts silent cycles only; any received byte restarts the inter-byte window
      r_rx_tmr <= w_in_frame && !w_rx ? r_rx_tmr + 1'b1 : '0;
      r_req <= w_in_frame && w_next == BUS ? 1'b1 : w_bus_end ? 1'b0 : r_req;
      r_bus_tmr <= r_req && !w_bus_end ? r_bus_tmr + 1'b1 : '0;
      r_gw_valid <= w_gw;
      r_overrun <= w_rx && (r_state == BUS || r_state == RSP);
      r_abort <= w_rx_tmo;
      r_btmo <= w_bus_tmo;
    end
  end
  always_comb begin
    io_su.tx_byte = w_tx_byte;
    io_su.tx_valid = w_tx_valid;
    io_su.gw_byte = r_gw_byte;
    io_su.gw_valid = r_gw_valid;
    io_su.bus_req = r_req;
    io_su.bus_we = r_req && r_wr;
    io_su.bus_addr = r_addr;
    io_su.bus_wdata = r_wdata;
    io_su.overrun = r_overrun;
    io_su.cmd_abort = r_abort;
    io_su.bus_timeout = r_btmo;
  end
endmodule

// File: tb/tb_smart_uart_cmd_engine.sv
// tb_smart_uart_cmd_engine: directed self-checking bench for the smart-UART command engine
module tb_smart_uart_cmd_engine;
  import smart_uart_pkg::*;
  localparam int RX_TMO = 200;
  localparam int BUS_TMO = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  smart_uart_cmd_engine_if io();
  smart_uart_cmd_engine #(
    .RX_TIMEOUT_CYC (RX_TMO),
    .BUS_TIMEOUT_CYC(BUS_TMO),
    .BUS_ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io_su(io)
  );
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int ack_dly = 0, tx_mode = 0, req_cyc = 0;
  logic [7:0] gw_q[$];
  logic [7:0] tx_q[$];
  int n_req = 0, n_req_cyc = 0, n_ovr = 0, n_abort = 0, n_btmo = 0, hold_err = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic cap_we = 1'b0;
  logic prev_req = 1'b0, prev_v = 1'b0, prev_r = 1'b0, prev_ack = 1'b0, txv_after_ack = 1'b0;
  logic [7:0] prev_b = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (io.gw_valid) gw_q.push_back(io.gw_byte);
    if (io.tx_valid && io.tx_ready) tx_q.push_back(io.tx_byte);
    if (io.bus_req && !prev_req) begin
      n_req++;
      cap_addr = io.bus_addr;
      cap_wdata = io.bus_wdata;
      cap_we = io.bus_we;
    end
    if (io.bus_req) n_req_cyc++;
    if (io.overrun) n_ovr++;
    if (io.cmd_abort) n_abort++;
    if (io.bus_timeout) n_btmo++;
    if (prev_v && !prev_r && (!io.tx_valid || io.tx_byte != prev_b)) hold_err++;
    if (prev_ack) txv_after_ack = io.tx_valid;
    prev_ack = io.bus_ack && io.bus_req;
    prev_req = io.bus_req;
    prev_v = io.tx_valid;
    prev_r = io.tx_ready;
    prev_b = io.tx_byte;
  end

  // bus responder and transmitter ready generator
  initial begin
    io.bus_ack = 1'b0;
    io.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      io.bus_ack = 1'b0;
      io.tx_ready = tx_mode == 0 ? 1'b1 : tx_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (io.bus_req) begin
        if (req_cyc == ack_dly) io.bus_ack = 1'b1;
        req_cyc++;
      end else req_cyc = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    io.rx_byte = b;
    io.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    io.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic wait_tx(input int n, input int lim);
    for (int i = 0; i < lim && tx_q.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    gw_q.delete();
    tx_q.delete();
    n_req = 0;
    n_req_cyc = 0;
    n_ovr = 0;
    n_abort = 0;
    n_btmo = 0;
    hold_err = 0;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] w);
    logic [39:0] e;
    e = {OPC_RSP, w};
    check({tag, "_n"}, 64'(tx_q.size()), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_b%0d", tag, i), i < tx_q.size() ? tx_q[i] : 8'hxx, e[39-8*i -: 8]);
  endtask

  initial begin
    logic [7:0] gw_exp [3];
    int t;
    gw_exp = '{8'h68, 8'h69, 8'h0A};
    io.rx_valid = 1'b0;
    io.rx_byte = '0;
    io.bus_rdata = '0;
    wait_cyc(3);
    check("rst_txv", io.tx_valid, 0);
    check("rst_txb", io.tx_byte, 0);
    check("rst_gwv", io.gw_valid, 0);
    check("rst_req", io.bus_req, 0);
    check("rst_addr", io.bus_addr, 0);
    check("rst_wdata", io.bus_wdata, 0);
    rst_n = 1'b1;
    wait_cyc(2);

    clr();
    ack_dly = 3;
    send(OPC_WR);
    send_word(32'h1000_0040);
    send_word(32'hCAFE_F00D);
    wait_cyc(10);
    check("wr_req", n_req, 1);
    check("wr_we", cap_we, 1);
    check("wr_addr", cap_addr, 32'h1000_0040);
    check("wr_wdata", cap_wdata, 32'hCAFE_F00D);
    check("wr_req_cyc", n_req_cyc, 4);
    check("wr_tx", tx_q.size(), 0);
    check("wr_gw", gw_q.size(), 0);

    clr();
    ack_dly = 0;
    tx_mode = 1;
    io.bus_rdata = 32'h1234_ABCD;
    send(OPC_RD);
    send_word(32'h0000_0010);
    check("rd_lat", io.bus_req, 1);
    wait_tx(5, 300);
    chk_rsp("rd", 32'h1234_ABCD);
    check("rd_addr", cap_addr, 32'h0000_0010);
    check("rd_we", cap_we, 0);
    check("rd_ack2tx", txv_after_ack, 1);
    check("rd_hold", hold_err, 0);
    check("rd_txv_end", io.tx_valid, 0);

    clr();
    tx_mode = 0;
    for (int i = 0; i < 3; i++) send(gw_exp[i]);
    wait_cyc(3);
    check("gw_n", gw_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("gw_b%0d", i), i < gw_q.size() ? gw_q[i] : 8'hxx, gw_exp[i]);
    check("gw_req", n_req, 0);
    check("gw_tx", tx_q.size(), 0);

    clr();
    send(OPC_RD);
    send(8'h00);
    send(8'h00);
    t = 0;
    while (!io.cmd_abort && t < RX_TMO + 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("abort_cyc", t, RX_TMO);
    wait_cyc(2);
    check("abort_n", n_abort, 1);
    check("abort_gw", gw_q.size(), 0);
    check("abort_req", n_req, 0);
    clr();
    ack_dly = 1;
    send(OPC_WR);
    send_word(32'hA0B0_C0D0);
    send_word(32'h1122_3344);
    wait_cyc(8);
    check("wr2_req", n_req, 1);
    check("wr2_we", cap_we, 1);
    check("wr2_addr", cap_addr, 32'hA0B0_C0D0);
    check("wr2_wdata", cap_wdata, 32'h1122_3344);

    clr();
    ack_dly = -1;
    send(OPC_RD);
    send_word(32'h0000_0020);
    wait_tx(5, BUS_TMO + 50);
    check("btmo_n", n_btmo, 1);
    check("btmo_req_cyc", n_req_cyc, BUS_TMO);
    chk_rsp("btmo", 32'hDEAD_BEEF);
    ack_dly = 0;

    clr();
    tx_mode = 2;
    io.bus_rdata = 32'h55AA_0FF0;
    send(OPC_RD);
    send_word(32'h0000_0044);
    wait_cyc(5);
    check("ovr_stall", io.tx_valid, 1);
    send(8'h41);
    wait_cyc(2);
    check("ovr_n", n_ovr, 1);
    check("ovr_gw", gw_q.size(), 0);
    tx_mode = 0;
    wait_tx(5, 50);
    chk_rsp("ovr", 32'h55AA_0FF0);
    check("ovr_hold", hold_err, 0);

    clr();
    send(OPC_WR);
    send(8'h12);
    send(8'h34);
    rst_n = 1'b0;
    wait_cyc(2);
    check("mrst_addr", io.bus_addr, 0);
    check("mrst_req", io.bus_req, 0);
    check("mrst_txv", io.tx_valid, 0);
    check("mrst_gwv", io.gw_valid, 0);
    rst_n = 1'b1;
    wait_cyc(1);
    io.bus_rdata = 32'h0102_0304;
    send(OPC_RD);
    send_word(32'h0000_0ABC);
    wait_tx(5, 50);
    chk_rsp("mrst", 32'h0102_0304);
    check("mrst_rd_addr", cap_addr, 32'h0000_0ABC);
    check("mrst_rd_req", n_req, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
